i2c_target_model: RTL and testbench

- Parametrised virtual I2C target for the Verilator top level, one instance per I2C bus.
- Gives the simulated Sonata system's I2C controllers a responding device, replacing today's undriven, pulled-high buses.
- Models a 7-bit-addressed register-file device: register pointer with auto-increment, repeated START, and optional clock stretching.
- Synthesisable; runs entirely from the system clock that oversamples the bus.

---
 rtl/i2c_model_pkg.sv | 22 ++
 rtl/i2c_bus_sync.sv | 40 ++++
 rtl/i2c_target_model.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_target_model.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_model_pkg.sv
// Shared types for the virtual I2C bus models: target FSM states, bus events
// and the ACK/NACK bus levels.
package i2c_model_pkg;

  typedef enum logic [3:0] {
    Idle, Addr, AddrAck, Ptr, PtrAck, WrData, WrAck, RdData, RdAck, Ignore
  } i2c_tgt_state_e;

  typedef enum logic [2:0] {
    EvNone, EvStart, EvStop, EvSclRise, EvSclFall
  } bus_ev_e;

  // SDA level seen on the ninth clock of a byte.
  localparam logic Ack  = 1'b0;
  localparam logic Nack = 1'b1;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] data;
  } wr_evt_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchroniser for SCL/SDA plus START/STOP/SCL-edge decode on the
// synchronised levels. START/STOP win over a coincident SCL edge.
module i2c_bus_sync import i2c_model_pkg::*; (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    scl_i,
  input  logic    sda_i,
  output logic    sda_o,
  output bus_ev_e ev_o
);

  logic [1:0] scl_ff, sda_ff;
  logic       scl_q, sda_q;

  // Reset to the idle (released) bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_i};
      sda_ff <= {sda_ff[0], sda_i};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign sda_o = sda_ff[1];

  always_comb begin
    ev_o = EvNone;
    if (scl_q && scl_ff[1] && sda_q && !sda_ff[1])      ev_o = EvStart;
    else if (scl_q && scl_ff[1] && !sda_q && sda_ff[1]) ev_o = EvStop;
    else if (!scl_q && scl_ff[1])                       ev_o = EvSclRise;
    else if (scl_q && !scl_ff[1])                       ev_o = EvSclFall;
  end

endmodule

// File: rtl/i2c_target_model.sv
// Virtual 7-bit-addressed I2C register-file target: auto-incrementing pointer,
// repeated START, optional clock stretch after each target ACK. Open-drain only.
module i2c_target_model import i2c_model_pkg::*; #(
  parameter logic [6:0] TargetAddr    = 7'h50,
  parameter int         NumRegs       = 16,
  parameter int         StretchCycles = 0,
  parameter logic [7:0] ResetValue    = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_idx_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);

  localparam int IW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam int SW = (StretchCycles > 1) ? $clog2(StretchCycles + 1) : 1;

  bus_ev_e        ev;
  logic           sda_s;
  i2c_tgt_state_e state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           ack_ph_q, ack_ph_d;
  logic           sda_oe_q, sda_oe_d;
  logic           busy_q, busy_d;

  logic [6:0]     shift_q;
  logic [7:0]     byte_nxt, rdata, rd_q;
  logic [IW-1:0]  ptr_q;
  logic [7:0]     regs_q [NumRegs];
  wr_evt_t        wr_q;
  logic           wr_valid_q, scl_oe_q;
  logic [SW-1:0]  st_cnt_q;
  logic           sh_in, wr_en, ptr_ld, ptr_inc, rd_ld, rd_sh, stretch_go;

  i2c_bus_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .sda_o  (sda_s),
    .ev_o   (ev)
  );

  assign byte_nxt = {shift_q, sda_s};
  assign rdata    = regs_q[ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      bit_cnt_q <= '0;
      ack_ph_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ack_ph_q  <= ack_ph_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
    end
  end

  // ack_ph marks that the SCL fall ending bit 8 has been seen, so the next
  // fall in an ACK state is the one ending the ninth (ACK) clock.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ack_ph_d   = ack_ph_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    sh_in      = 1'b0;
    wr_en      = 1'b0;
    ptr_ld     = 1'b0;
    ptr_inc    = 1'b0;
    rd_ld      = 1'b0;
    rd_sh      = 1'b0;
    stretch_go = 1'b0;
    case (ev)
      EvStart: begin
        state_d   = Addr;
        bit_cnt_d = '0;
        ack_ph_d  = 1'b0;
        sda_oe_d  = 1'b0;
      end
      EvStop: begin
        state_d   = Idle;
        bit_cnt_d = '0;
        ack_ph_d  = 1'b0;
        sda_oe_d  = 1'b0;
        busy_d    = 1'b0;
      end
      EvSclRise: begin
        case (state_q)
          Addr, Ptr, WrData: begin
            sh_in     = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                Addr: begin
                  if (byte_nxt[7:1] == TargetAddr) begin
                    state_d = AddrAck;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = Ignore;
                  end
                end
                Ptr: begin
                  state_d = PtrAck;
                  ptr_ld  = 1'b1;
                end
                default: begin
                  state_d = WrAck;
                  wr_en   = 1'b1;
                  ptr_inc = 1'b1;
                end
              endcase
            end
          end
          RdData: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = RdAck;
              ptr_inc = 1'b1;
            end
          end
          RdAck: if (ack_ph_q && sda_s == Nack) state_d = Ignore;
          default: ;
        endcase
      end
      EvSclFall: begin
        case (state_q)
          AddrAck, PtrAck, WrAck: begin
            if (!ack_ph_q) begin
              sda_oe_d = ~Ack;
              ack_ph_d = 1'b1;
            end else begin
              ack_ph_d   = 1'b0;
              bit_cnt_d  = '0;
              stretch_go = 1'b1;
              sda_oe_d   = 1'b0;
              state_d    = WrData;
              // shift_q[0] still holds the R/W bit of the address byte.
              if (state_q == AddrAck) begin
                if (shift_q[0]) begin
                  state_d  = RdData;
                  rd_ld    = 1'b1;
                  sda_oe_d = ~rdata[7];
                end else begin
                  state_d = Ptr;
                end
              end
            end
          end
          RdData: begin
            rd_sh    = 1'b1;
            sda_oe_d = ~rd_q[7];
          end
          RdAck: begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b0;
              ack_ph_d = 1'b1;
            end else begin
              ack_ph_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = RdData;
              rd_ld     = 1'b1;
              sda_oe_d  = ~rdata[7];
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // rd_q holds the bits still to be driven, next one in bit 7.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= ResetValue;
      shift_q    <= '0;
      ptr_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      wr_valid_q <= 1'b0;
      scl_oe_q   <= 1'b0;
      st_cnt_q   <= '0;
    end else begin
      wr_valid_q <= wr_en;
      if (sh_in) shift_q <= byte_nxt[6:0];
      if (wr_en) begin
        regs_q[ptr_q] <= byte_nxt;
        wr_q          <= {8'(ptr_q), byte_nxt};
      end
      if (ptr_ld)       ptr_q <= IW'(int'(byte_nxt) % NumRegs);
      else if (ptr_inc) ptr_q <= (ptr_q == IW'(NumRegs - 1)) ? '0 : ptr_q + 1'b1;
      if (rd_ld)        rd_q <= {rdata[6:0], 1'b0};
      else if (rd_sh)   rd_q <= {rd_q[6:0], 1'b0};
      if (stretch_go && StretchCycles != 0) begin
        scl_oe_q <= 1'b1;
        st_cnt_q <= SW'(StretchCycles - 1);
      end else if (scl_oe_q) begin
        if (st_cnt_q == '0) scl_oe_q <= 1'b0;
        else                st_cnt_q <= st_cnt_q - 1'b1;
      end
    end
  end

  assign scl_oe_o   = scl_oe_q;
  assign sda_oe_o   = sda_oe_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_idx_o   = wr_q.idx;
  assign wr_data_o  = wr_q.data;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target_model.sv
// Bench for i2c_target_model: a bit-banged I2C controller drives the bus; writes
// and read bytes are checked against scoreboard queues filled as stimulus is sent.
module tb_i2c_target_model;
  import i2c_model_pkg::*;

  localparam int Q       = 8;
  localparam int Stretch = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1, sda_drv = 1'b1;
  logic       scl, sda;
  logic       scl_oe, sda_oe, wr_valid, busy;
  logic [7:0] wr_idx, wr_data;

  int         checks = 0, errors = 0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] w;
  logic        sda_oe_seen = 1'b0;
  int          oe_run = 0, last_run = 0, last_wait = 0;

  always #5 clk = ~clk;

  assign scl = scl_drv & ~scl_oe;
  assign sda = sda_drv & ~sda_oe;

  i2c_target_model #(
    .TargetAddr    (7'h50),
    .NumRegs       (16),
    .StretchCycles (Stretch),
    .ResetValue    (8'h00)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .scl_oe_o   (scl_oe),
    .sda_oe_o   (sda_oe),
    .wr_valid_o (wr_valid),
    .wr_idx_o   (wr_idx),
    .wr_data_o  (wr_data),
    .busy_o     (busy)
  );

  // Bus monitor: write scoreboard, SDA-drive flag, stretch run length.
  initial forever begin
    @(negedge clk);
    if (sda_oe) sda_oe_seen = 1'b1;
    if (scl_oe) oe_run++;
    else if (oe_run != 0) begin last_run = oe_run; oe_run = 0; end
    if (rst_n && wr_valid) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got idx=%0d data=%h want none", wr_idx, wr_data);
      end else begin
        w = exp_wr.pop_front();
        if ({wr_idx, wr_data} !== w) begin
          errors++;
          $display("FAIL write got idx=%0d data=%h want idx=%0d data=%h", wr_idx, wr_data, w[15:8], w[7:0]);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_up();
    int n = 0;
    scl_drv = 1'b1;
    #1;
    while (scl !== 1'b1 && n < 400) begin cyc(1); n++; end
    last_wait = n;
    if (scl !== 1'b1) begin
      checks++; errors++;
      $display("FAIL scl_release_timeout got=%b want=1", scl);
    end
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    sda_drv = b; cyc(Q);
    scl_up();    cyc(Q);
    r = sda;     cyc(Q);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic tx_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, ack);
  endtask

  task automatic rx_byte(input logic ack_in, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
    xfer_bit(ack_in, r);
  endtask

  task automatic start_cond();
    if (scl_drv == 1'b0) begin
      sda_drv = 1'b1; cyc(Q);
      scl_up();       cyc(Q);
    end
    sda_drv = 1'b0; cyc(Q);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic stop_cond();
    sda_drv = 1'b0; cyc(Q);
    scl_up();       cyc(Q);
    sda_drv = 1'b1; cyc(2 * Q);
  endtask

  task automatic test_reset();
    cyc(3);
    checks++;
    if ({scl_oe, sda_oe, wr_valid, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000", {scl_oe, sda_oe, wr_valid, busy});
    end
    checks++;
    if ({wr_idx, wr_data} !== 16'h0000) begin
      errors++; $display("FAIL reset_wr_bus got=%h want=0000", {wr_idx, wr_data});
    end
    rst_n = 1'b1;
    cyc(4);
  endtask

  task automatic test_write();
    logic [3:0] a;
    start_cond();
    tx_byte(8'hA0, a[0]);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_set got=%b want=1", busy); end
    tx_byte(8'h03, a[1]);
    exp_wr.push_back({8'd3, 8'h11}); tx_byte(8'h11, a[2]);
    exp_wr.push_back({8'd4, 8'h22}); tx_byte(8'h22, a[3]);
    stop_cond();
    checks++;
    if (a !== 4'b0000) begin errors++; $display("FAIL wr_acks got=%b want=0000", a); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_clear got=%b want=0", busy); end
    checks++;
    if (exp_wr.size() != 0) begin errors++; $display("FAIL wr_missing got=%0d pending want=0", exp_wr.size()); end
  endtask

  task automatic read_from(input logic [7:0] ptr, input int nbytes);
    logic [2:0] a;
    logic [7:0] d, e;
    start_cond();
    tx_byte(8'hA0, a[0]);
    tx_byte(ptr, a[1]);
    start_cond();
    tx_byte(8'hA1, a[2]);
    checks++;
    if (a !== 3'b000) begin errors++; $display("FAIL rd_acks got=%b want=000", a); end
    for (int i = 0; i < nbytes; i++) begin
      rx_byte(i == nbytes - 1, d);
      e = exp_rd.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL rd_data got=%h want=%h", d, e); end
    end
    cyc(4);
    checks++;
    if (sda_oe !== 1'b0 || sda !== 1'b1) begin
      errors++; $display("FAIL rd_nack_release got oe=%b sda=%b want oe=0 sda=1", sda_oe, sda);
    end
    stop_cond();
  endtask

  task automatic test_read_rs();
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'h22);
    read_from(8'h03, 2);
  endtask

  task automatic test_wrong_addr();
    logic [1:0] a;
    sda_oe_seen = 1'b0;
    start_cond();
    tx_byte(8'hA2, a[0]);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wa_busy got=%b want=0", busy); end
    tx_byte(8'h00, a[1]);
    stop_cond();
    checks++;
    if (a !== 2'b11) begin errors++; $display("FAIL wa_nacks got=%b want=11", a); end
    checks++;
    if (sda_oe_seen !== 1'b0) begin errors++; $display("FAIL wa_sda_driven got=%b want=0", sda_oe_seen); end
  endtask

  task automatic test_wrap();
    logic [3:0] a;
    start_cond();
    tx_byte(8'hA0, a[0]);
    tx_byte(8'h0F, a[1]);
    exp_wr.push_back({8'd15, 8'hAA}); tx_byte(8'hAA, a[2]);
    exp_wr.push_back({8'd0,  8'hBB}); tx_byte(8'hBB, a[3]);
    stop_cond();
    checks++;
    if (a !== 4'b0000) begin errors++; $display("FAIL wrap_acks got=%b want=0000", a); end
    checks++;
    if (exp_wr.size() != 0) begin errors++; $display("FAIL wrap_missing got=%0d pending want=0", exp_wr.size()); end
    exp_rd.push_back(8'hAA);
    exp_rd.push_back(8'hBB);
    read_from(8'h0F, 2);
  endtask

  task automatic test_stretch();
    logic a, r;
    last_run = 0;
    start_cond();
    tx_byte(8'hA0, a);
    xfer_bit(1'b0, r);
    checks++;
    if (last_run != Stretch) begin errors++; $display("FAIL stretch_len got=%0d want=%0d", last_run, Stretch); end
    checks++;
    if (last_wait == 0) begin errors++; $display("FAIL stretch_delay got=%0d cycles want>0", last_wait); end
    stop_cond();
  endtask

  task automatic test_abort_stop();
    logic [1:0] a;
    logic r;
    start_cond();
    tx_byte(8'hA0, a[0]);
    tx_byte(8'h00, a[1]);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, r);
    stop_cond();
    cyc(4);
    checks++;
    if (dut.state_q !== Idle) begin errors++; $display("FAIL abort_state got=%0d want=%0d", dut.state_q, Idle); end
    checks++;
    if ({busy, sda_oe, scl_oe} !== 3'b000) begin
      errors++; $display("FAIL abort_outputs got=%b want=000", {busy, sda_oe, scl_oe});
    end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] a;
    exp_wr.push_back({8'd3, 8'h5C});
    start_cond();
    tx_byte(8'hA0, a[0]);
    tx_byte(8'h03, a[1]);
    tx_byte(8'h5C, a[2]);
    stop_cond();
    start_cond();
    tx_byte(8'hA0, a[3]);
    tx_byte(8'h03, a[3]);
    start_cond();
    tx_byte(8'hA1, a[3]);
    // First read bit of 0x5C is 0 and the ACK stretch is still running.
    checks++;
    if ({sda_oe, scl_oe} !== 2'b11) begin
      errors++; $display("FAIL mid_read_drive got=%b want=11", {sda_oe, scl_oe});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sda_oe, scl_oe, busy} !== 3'b000) begin
      errors++; $display("FAIL async_reset_oe got=%b want=000", {sda_oe, scl_oe, busy});
    end
    scl_drv = 1'b1; cyc(2);
    sda_drv = 1'b1; cyc(2);
    rst_n = 1'b1;   cyc(4);
    exp_rd.push_back(8'h00);
    read_from(8'h03, 1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_rs();
    test_wrong_addr();
    test_wrap();
    test_stretch();
    test_abort_stop();
    test_reset_mid_read();
    cyc(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
